// File: rtl/rd_tid_scheduler_pkg.sv
// Shared defaults, tID type and FSM state encoding for the read-path tID scheduler.
package rd_tid_scheduler_pkg;

    localparam int AXI_ID_WIDTH        = 4;
    localparam int FIFO_SIZE           = 8;
    localparam int TID_MAX_DEF         = 16;
    localparam int MAX_OUTSTANDING_DEF = FIFO_SIZE;
    localparam int TID_W               = $clog2(TID_MAX_DEF);

    typedef logic [TID_W-1:0] tid_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2
    } state_e;

endpackage

// File: rtl/rd_tid_scheduler_if.sv
// AR-in / lookup-request-out / retire / flush signal bundle of the tID scheduler.
interface rd_tid_scheduler_if #(
    parameter int ID_WIDTH        = rd_tid_scheduler_pkg::AXI_ID_WIDTH,
    parameter int ADDR_WIDTH      = 64,
    parameter int TID_MAX         = rd_tid_scheduler_pkg::TID_MAX_DEF,
    parameter int MAX_OUTSTANDING = rd_tid_scheduler_pkg::MAX_OUTSTANDING_DEF
);
    localparam int TID_BITS = $clog2(TID_MAX);
    localparam int CNT_BITS = $clog2(MAX_OUTSTANDING + 1);

    logic                  ar_valid_i;
    logic                  ar_ready_o;
    logic [ID_WIDTH-1:0]   ar_id_i;
    logic [ADDR_WIDTH-1:0] ar_addr_i;
    logic                  req_valid_o;
    logic                  req_ready_i;
    logic [TID_BITS-1:0]   req_tid_o;
    logic [ADDR_WIDTH-1:0] req_addr_o;
    logic                  retire_i;
    logic [TID_BITS-1:0]   retire_tid_i;
    logic [ID_WIDTH-1:0]   rsp_id_o;
    logic                  flush_i;
    logic                  flush_done_o;
    logic [CNT_BITS-1:0]   outstanding_o;
    logic                  order_err_o;

    modport slave (
        input  ar_valid_i, ar_id_i, ar_addr_i, req_ready_i,
               retire_i, retire_tid_i, flush_i,
        output ar_ready_o, req_valid_o, req_tid_o, req_addr_o,
               rsp_id_o, flush_done_o, outstanding_o, order_err_o
    );

    modport master (
        output ar_valid_i, ar_id_i, ar_addr_i, req_ready_i,
               retire_i, retire_tid_i, flush_i,
        input  ar_ready_o, req_valid_o, req_tid_o, req_addr_o,
               rsp_id_o, flush_done_o, outstanding_o, order_err_o
    );

endinterface

// File: rtl/rd_tid_scheduler_tid_id_table.sv
// Per-tID storage of the original AXI ID: one synchronous write port, one combinational read port.
module rd_tid_scheduler_tid_id_table #(
    parameter int ID_WIDTH = 4,
    parameter int DEPTH    = 16,
    parameter int AW       = 4
) (
    input  logic                clk,
    input  logic                we,
    input  logic [AW-1:0]       waddr,
    input  logic [ID_WIDTH-1:0] wdata,
    input  logic [AW-1:0]       raddr,
    output logic [ID_WIDTH-1:0] rdata
);
    logic [ID_WIDTH-1:0] mem_r [DEPTH];

    // Capture the AXI ID of each accepted request at its tID slot
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata = mem_r[raddr];

endmodule

// File: rtl/rd_tid_scheduler.sv
// Read-path front end: tags AXI AR requests with sequential tIDs, bounds in-flight
// reads to the ROB FIFO depth, and drains/rewinds the tID counters on flush.
module rd_tid_scheduler
    import rd_tid_scheduler_pkg::*;
#(
    parameter int ID_WIDTH        = AXI_ID_WIDTH,
    parameter int ADDR_WIDTH      = 64,
    parameter int TID_MAX         = TID_MAX_DEF,
    parameter int MAX_OUTSTANDING = MAX_OUTSTANDING_DEF
) (
    input logic               clk,
    input logic               rst_n,
    rd_tid_scheduler_if.slave bus
);
    localparam int TID_BITS = $clog2(TID_MAX);
    localparam int CNT_BITS = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [TID_BITS-1:0] TID_ZERO  = {TID_BITS{1'b0}};
    localparam logic [TID_BITS-1:0] TID_LAST  = TID_BITS'(TID_MAX - 1);
    localparam logic [CNT_BITS-1:0] CNT_ZERO  = {CNT_BITS{1'b0}};
    localparam logic [CNT_BITS-1:0] CNT_ONE   = CNT_BITS'(1);
    localparam logic [CNT_BITS-1:0] CNT_LIMIT = CNT_BITS'(MAX_OUTSTANDING);

    function automatic logic [TID_BITS-1:0] tid_next(input logic [TID_BITS-1:0] t);
        logic [TID_BITS-1:0] n;
        if (t == TID_LAST) begin
            n = TID_ZERO;
        end else begin
            n = t + TID_BITS'(1);
        end
        return n;
    endfunction

    state_e                state_r, state_nx_s;
    logic [TID_BITS-1:0]   alloc_tid_r, exp_tid_r, req_tid_r;
    logic [CNT_BITS-1:0]   outstanding_r, outstanding_nx_s;
    logic [ADDR_WIDTH-1:0] req_addr_r;
    logic                  req_valid_r, flush_pending_r, flush_done_r, order_err_r;
    logic                  ar_ready_s, ar_fire_s, retire_dec_s, retire_err_s, drain_done_s;
    logic [ID_WIDTH-1:0]   rsp_id_s;

    // Admission: issue slot free (or freeing), a credit left, and no flush in progress
    always_comb begin
        ar_ready_s = 1'b0;
        if (rst_n && ((state_r == S_IDLE) || ((state_r == S_ISSUE) && bus.req_ready_i)) &&
            (outstanding_r < CNT_LIMIT) && !flush_pending_r && !bus.flush_i) begin
            ar_ready_s = 1'b1;
        end else begin
            ar_ready_s = 1'b0;
        end
    end

    assign ar_fire_s    = bus.ar_valid_i && ar_ready_s;
    // A retire with nothing in flight is flagged but never underflows the counters
    assign retire_dec_s = bus.retire_i && (outstanding_r != CNT_ZERO);
    assign retire_err_s = bus.retire_i &&
                          ((bus.retire_tid_i != exp_tid_r) || (outstanding_r == CNT_ZERO));
    assign drain_done_s = (state_r == S_DRAIN) && (outstanding_r == CNT_ZERO);

    // In-flight count: a same-cycle accept and retire cancel out
    always_comb begin
        outstanding_nx_s = outstanding_r;
        if (ar_fire_s && !retire_dec_s) begin
            outstanding_nx_s = outstanding_r + CNT_ONE;
        end else if (!ar_fire_s && retire_dec_s) begin
            outstanding_nx_s = outstanding_r - CNT_ONE;
        end else begin
            outstanding_nx_s = outstanding_r;
        end
    end

    // Next-state decode for the issue/drain FSM
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (ar_fire_s) begin
                    state_nx_s = S_ISSUE;
                end else if (flush_pending_r || bus.flush_i) begin
                    state_nx_s = S_DRAIN;
                end else begin
                    state_nx_s = S_IDLE;
                end
            end
            S_ISSUE: begin
                if (!bus.req_ready_i || ar_fire_s) begin
                    state_nx_s = S_ISSUE;
                end else if (flush_pending_r) begin
                    state_nx_s = S_DRAIN;
                end else begin
                    state_nx_s = S_IDLE;
                end
            end
            S_DRAIN: begin
                if (outstanding_r == CNT_ZERO) begin
                    state_nx_s = S_IDLE;
                end else begin
                    state_nx_s = S_DRAIN;
                end
            end
            default: state_nx_s = S_IDLE;
        endcase
    end

    // FSM, tID counters, credit counter and all registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r         <= S_IDLE;
            alloc_tid_r     <= TID_ZERO;
            exp_tid_r       <= TID_ZERO;
            outstanding_r   <= CNT_ZERO;
            flush_pending_r <= 1'b0;
            flush_done_r    <= 1'b0;
            order_err_r     <= 1'b0;
            req_valid_r     <= 1'b0;
            req_tid_r       <= TID_ZERO;
            req_addr_r      <= {ADDR_WIDTH{1'b0}};
        end else begin
            state_r       <= state_nx_s;
            outstanding_r <= outstanding_nx_s;
            // Registered so the pulse lines up with the first S_DRAIN cycle that sees zero in flight
            flush_done_r  <= (state_nx_s == S_DRAIN) && (outstanding_nx_s == CNT_ZERO);
            order_err_r   <= order_err_r || retire_err_s;

            if (ar_fire_s) begin
                req_valid_r <= 1'b1;
                req_tid_r   <= alloc_tid_r;
                req_addr_r  <= bus.ar_addr_i;
            end else if ((state_r == S_ISSUE) && bus.req_ready_i) begin
                req_valid_r <= 1'b0;
            end else begin
                req_valid_r <= req_valid_r;
            end

            if (drain_done_s) begin
                alloc_tid_r <= TID_ZERO;
                exp_tid_r   <= TID_ZERO;
            end else begin
                if (ar_fire_s) begin
                    alloc_tid_r <= tid_next(alloc_tid_r);
                end
                if (retire_dec_s) begin
                    exp_tid_r <= tid_next(exp_tid_r);
                end
            end

            if (drain_done_s) begin
                flush_pending_r <= 1'b0;
            end else if (bus.flush_i && (state_r != S_DRAIN)) begin
                flush_pending_r <= 1'b1;
            end else begin
                flush_pending_r <= flush_pending_r;
            end
        end
    end

    rd_tid_scheduler_tid_id_table #(
        .ID_WIDTH (ID_WIDTH),
        .DEPTH    (TID_MAX),
        .AW       (TID_BITS)
    ) u_id_table (
        .clk   (clk),
        .we    (ar_fire_s),
        .waddr (alloc_tid_r),
        .wdata (bus.ar_id_i),
        .raddr (bus.retire_tid_i),
        .rdata (rsp_id_s)
    );

    assign bus.ar_ready_o    = ar_ready_s;
    assign bus.req_valid_o   = req_valid_r;
    assign bus.req_tid_o     = req_tid_r;
    assign bus.req_addr_o    = req_addr_r;
    assign bus.rsp_id_o      = rsp_id_s;
    assign bus.flush_done_o  = flush_done_r;
    assign bus.outstanding_o = outstanding_r;
    assign bus.order_err_o   = order_err_r;

endmodule

// File: doc/rd_tid_scheduler.md
Name: rd_tid_scheduler

Overview:
Front-end scheduler for the DRAM-cache read path. It accepts AXI AR requests and tags each one with a sequential transaction ID (tID, modulo TID_MAX). It issues the tagged request to the tag-compare lookup stage and stores the original AXI ID per tID for response reconstruction. It limits in-flight reads so the reorder buffer's hit and miss FIFOs can never overflow. It supports a drain/flush that quiesces the path and rewinds the tID counters to 0.

Parameters:
ID_WIDTH, `AXI_ID_WIDTH, AXI ID width
ADDR_WIDTH, 64, AXI address width
TID_MAX, `TID_MAX (16), tID modulus; TID_W = $clog2(TID_MAX)
MAX_OUTSTANDING, `FIFO_SIZE (8), in-flight read limit; must be <= TID_MAX and <= FIFO_SIZE

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
ar_valid_i  in  1  AXI AR valid
ar_ready_o  out  1  AXI AR ready
ar_id_i  in  ID_WIDTH  AXI AR ID
ar_addr_i  in  ADDR_WIDTH  AXI AR address
req_valid_o  out  1  lookup request valid
req_ready_i  in  1  lookup stage ready
req_tid_o  out  TID_W  assigned tID
req_addr_o  out  ADDR_WIDTH  request address
retire_i  in  1  ROB response handshake (R valid & ready)
retire_tid_i  in  TID_W  tID being retired
rsp_id_o  out  ID_WIDTH  AXI ID stored for retire_tid_i (combinational)
flush_i  in  1  drain request pulse
flush_done_o  out  1  one-cycle pulse when drain completes
outstanding_o  out  $clog2(MAX_OUTSTANDING+1)  in-flight count
order_err_o  out  1  sticky retire-order error

Behaviour:
- Reset (clk, rst_n synchronous active-low): state=S_IDLE; alloc_tid=0, exp_tid=0, outstanding=0; flush_pending=0; all outputs 0 (rsp_id_o = id_table[retire_tid_i]; table contents are don't-care).
- States: S_IDLE (no request held), S_ISSUE (request held on req_*), S_DRAIN (waiting for outstanding==0).
- ar_ready_o is combinational: (state==S_IDLE || (state==S_ISSUE && req_ready_i)) && outstanding<MAX_OUTSTANDING && !flush_pending && !flush_i.
- AR handshake:
  - req_addr/req_tid are registered from ar_addr_i/alloc_tid.
  - id_table[alloc_tid] <= ar_id_i.
  - alloc_tid increments, wrapping TID_MAX-1 -> 0.
  - outstanding increments.
  - req_valid_o=1 next cycle; latency AR to req is 1 cycle.
- S_IDLE: on AR handshake, go to S_ISSUE. If flush_pending or flush_i, go to S_DRAIN.
- S_ISSUE: req_* held stable while !req_ready_i.
  - On req_ready_i with a new AR handshake in the same cycle, stay in S_ISSUE with the new request (back-to-back, 1 req/cycle).
  - On req_ready_i with no new AR: req_valid_o=0; go to S_DRAIN if flush_pending, else S_IDLE.
- Flush:
  - flush_i sets flush_pending; flush_i during S_DRAIN is ignored.
  - S_DRAIN: when outstanding==0, flush_done_o=1 for one cycle, alloc_tid=exp_tid=0, flush_pending=0, go to S_IDLE.
  - If outstanding==0 already on entry, flush_done_o fires in the first S_DRAIN cycle.
- Retire:
  - retire_i decrements outstanding and increments exp_tid (wrap).
  - Retire and AR handshake in the same cycle: outstanding unchanged.
  - The credit check uses the registered outstanding value; a same-cycle retire does not free a credit until the next cycle.
- order_err_o is set (sticky until reset) if retire_i && (retire_tid_i != exp_tid || outstanding==0). In the outstanding==0 case the counters are not decremented (no underflow).
- Retire does not change FSM state.

Decomposition:
- Shared TYPEDEF package: TID_W, the tid_t typedef, the S_IDLE/S_ISSUE/S_DRAIN state encoding, and the MAX_OUTSTANDING default alias of FIFO_SIZE.
- One natural sub-module: tid_id_table, a TID_MAX x ID_WIDTH register file with a synchronous write and one combinational read port, reset-free.
- Counters and FSM stay in the top module.

Test Plan:
- Single read: AR id=3 addr=0x100 -> next cycle req_valid=1, req_tid=0, req_addr=0x100; after req_ready, retire tid 0 -> rsp_id_o=3, outstanding back to 0.
- Credit limit: 9 ARs, req_ready=1, no retires -> 8 accepted (tids 0..7), ar_ready=0 with outstanding=8; one retire -> ar_ready=1 the following cycle, 9th gets tid 8.
- Wrap: 20 ARs, each retired in order -> tids run 0..15,0..3; order_err stays 0.
- Back-to-back with backpressure: req_ready low for 3 cycles -> req_* stable, ar_ready=0; req_ready high -> one request per cycle.
- Simultaneous AR and retire at outstanding=5 -> outstanding stays 5.
- Flush with 3 outstanding -> ar_ready=0 until 3 retires; flush_done pulses once; the next AR gets tid 0.
- Out-of-order retire: retire tid 2 when exp_tid=0 -> order_err_o=1 and stays set until reset.
